// File: rtl/lcd_timing_pkg.sv
// Shared types and panel timing sets for the RGB-LCD timing generator.
// Widths here are the single source for coordinate and pixel buses.
package lcd_timing_pkg;

  localparam int PIX_W = 24;
  localparam int CRD_W = 11;

  typedef logic [PIX_W-1:0] rgb_t;
  typedef logic [CRD_W-1:0] crd_t;

  localparam rgb_t BLACK = 24'h000000;
  localparam rgb_t WHITE = 24'hFFFFFF;

  // 800x480 panel
  localparam int P800_H_SYNC  = 128;
  localparam int P800_H_BACK  = 88;
  localparam int P800_H_DISP  = 800;
  localparam int P800_H_FRONT = 40;
  localparam int P800_V_SYNC  = 2;
  localparam int P800_V_BACK  = 33;
  localparam int P800_V_DISP  = 480;
  localparam int P800_V_FRONT = 10;

  // 480x272 panel
  localparam int P480_H_SYNC  = 41;
  localparam int P480_H_BACK  = 2;
  localparam int P480_H_DISP  = 480;
  localparam int P480_H_FRONT = 2;
  localparam int P480_V_SYNC  = 10;
  localparam int P480_V_BACK  = 2;
  localparam int P480_V_DISP  = 272;
  localparam int P480_V_FRONT = 2;

  function automatic int line_total(
    int sync, int back, int disp, int front
  );
    return sync + back + disp + front;
  endfunction

endpackage

// File: rtl/lcd_timing_gen_if.sv
// Pixel request bus between the timing generator and the content stage.
// Coordinates flow out, registered pixel data flows back one pclk later.
interface lcd_timing_gen_if;
  import lcd_timing_pkg::*;

  crd_t pixel_xpos;
  crd_t pixel_ypos;
  crd_t h_disp;
  crd_t v_disp;
  rgb_t pixel_data;

  modport master (
    output pixel_xpos,
    output pixel_ypos,
    output h_disp,
    output v_disp,
    input  pixel_data
  );

  modport slave (
    input  pixel_xpos,
    input  pixel_ypos,
    input  h_disp,
    input  v_disp,
    output pixel_data
  );

endinterface

// File: rtl/lcd_sync_cnt.sv
// Wrapping raster counter with enable and carry-out.
// carry is high in the enabled cycle that wraps the count back to zero.
module lcd_sync_cnt #(
  parameter int W     = 11,
  parameter int TOTAL = 1056
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         carry
);

  localparam logic [W-1:0] LAST = W'(TOTAL - 1);

  assign carry = en && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (carry) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/lcd_timing_gen.sv
// RGB-LCD raster timing: sync/enable decode, coordinate requests one
// pclk ahead of de, and blanking-aware RGB output to the panel.
module lcd_timing_gen
  import lcd_timing_pkg::*;
#(
  parameter int H_SYNC  = P800_H_SYNC,
  parameter int H_BACK  = P800_H_BACK,
  parameter int H_DISP  = P800_H_DISP,
  parameter int H_FRONT = P800_H_FRONT,
  parameter int V_SYNC  = P800_V_SYNC,
  parameter int V_BACK  = P800_V_BACK,
  parameter int V_DISP  = P800_V_DISP,
  parameter int V_FRONT = P800_V_FRONT
) (
  input  logic lcd_pclk,
  input  logic rst_n,
  lcd_timing_gen_if.master pix,
  output logic lcd_hs,
  output logic lcd_vs,
  output logic lcd_de,
  output rgb_t lcd_rgb,
  output logic lcd_bl,
  output logic frame_start
);

  localparam int H_TOTAL =
    line_total(H_SYNC, H_BACK, H_DISP, H_FRONT);
  localparam int V_TOTAL =
    line_total(V_SYNC, V_BACK, V_DISP, V_FRONT);
  localparam int H_ACT = H_SYNC + H_BACK;
  localparam int V_ACT = V_SYNC + V_BACK;

  localparam crd_t HS_END  = crd_t'(H_SYNC);
  localparam crd_t VS_END  = crd_t'(V_SYNC);
  localparam crd_t DE_BEG  = crd_t'(H_ACT);
  localparam crd_t DE_END  = crd_t'(H_ACT + H_DISP);
  localparam crd_t REQ_BEG = crd_t'(H_ACT - 1);
  localparam crd_t REQ_END = crd_t'(H_ACT + H_DISP - 1);
  localparam crd_t VA_BEG  = crd_t'(V_ACT);
  localparam crd_t VA_END  = crd_t'(V_ACT + V_DISP);

  // The request window sits one pclk before de, so it needs H_ACT >= 1.
  if (H_ACT < 1) begin : g_h_act_chk
    $error("lcd_timing_gen: H_SYNC+H_BACK must be at least 1");
  end

  crd_t h_cnt;
  crd_t v_cnt;
  logic h_wrap;
  logic v_wrap_unused;
  logic v_act;
  logic data_req;

  lcd_sync_cnt #(
    .W     (CRD_W),
    .TOTAL (H_TOTAL)
  ) u_h_cnt (
    .clk   (lcd_pclk),
    .rst_n (rst_n),
    .en    (1'b1),
    .cnt   (h_cnt),
    .carry (h_wrap)
  );

  lcd_sync_cnt #(
    .W     (CRD_W),
    .TOTAL (V_TOTAL)
  ) u_v_cnt (
    .clk   (lcd_pclk),
    .rst_n (rst_n),
    .en    (h_wrap),
    .cnt   (v_cnt),
    .carry (v_wrap_unused)
  );

  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      lcd_bl <= 1'b0;
    end else begin
      lcd_bl <= 1'b1;
    end
  end

  always_comb begin
    v_act    = (v_cnt >= VA_BEG) && (v_cnt < VA_END);
    lcd_hs   = (h_cnt >= HS_END);
    lcd_vs   = (v_cnt >= VS_END);
    lcd_de   = v_act && (h_cnt >= DE_BEG) && (h_cnt < DE_END);
    data_req = v_act && (h_cnt >= REQ_BEG) && (h_cnt < REQ_END);
  end

  always_comb begin
    pix.pixel_xpos = '0;
    pix.pixel_ypos = '0;
    if (data_req) begin
      pix.pixel_xpos = h_cnt - REQ_BEG;
      pix.pixel_ypos = v_cnt - VA_BEG;
    end
  end

  assign pix.h_disp = crd_t'(H_DISP);
  assign pix.v_disp = crd_t'(V_DISP);

  assign frame_start = (h_cnt == REQ_BEG) && (v_cnt == VA_BEG);
  assign lcd_rgb     = lcd_de ? pix.pixel_data : BLACK;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Directed bench for lcd_timing_gen on a reduced raster, with an RGB
// scoreboard fed by coordinate requests and drained on de cycles.
module tb_lcd_timing_gen;
  import lcd_timing_pkg::*;

  localparam int HS = 4, HB = 3, HD = 10, HF = 2;
  localparam int VS = 2, VB = 3, VD = 5, VF = 2;
  localparam int HT = HS + HB + HD + HF;
  localparam int VT = VS + VB + VD + VF;
  localparam int HA = HS + HB;
  localparam int VA = VS + VB;
  localparam int FR = HT * VT;

  logic lcd_pclk = 1'b0;
  logic rst_n = 1'b0;
  logic lcd_hs, lcd_vs, lcd_de, lcd_bl, frame_start;
  rgb_t lcd_rgb;

  lcd_timing_gen_if pif ();

  lcd_timing_gen #(
    .H_SYNC (HS), .H_BACK (HB), .H_DISP (HD), .H_FRONT (HF),
    .V_SYNC (VS), .V_BACK (VB), .V_DISP (VD), .V_FRONT (VF)
  ) dut (
    .lcd_pclk    (lcd_pclk),
    .rst_n       (rst_n),
    .pix         (pif),
    .lcd_hs      (lcd_hs),
    .lcd_vs      (lcd_vs),
    .lcd_de      (lcd_de),
    .lcd_rgb     (lcd_rgb),
    .lcd_bl      (lcd_bl),
    .frame_start (frame_start)
  );

  always #5 lcd_pclk = ~lcd_pclk;

  bit white = 1'b0;

  // Content stage: one-pclk registered lookup of the requested pixel.
  always_ff @(posedge lcd_pclk) begin
    if (white)
      pif.pixel_data <= WHITE;
    else
      pif.pixel_data <= {pif.pixel_ypos[7:0], pif.pixel_xpos, 5'b0};
  end

  int total = 0;
  int bad = 0;
  int n, edges, cyc;
  int de_cnt, hs_cnt, vs_cnt, fs_cnt;
  int last_fall;
  logic prev_vs;
  rgb_t sb[$];

  task automatic chk(string tag, logic [31:0] a, logic [31:0] e);
    total++;
    assert (a === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, a, e);
    end
  endtask

  task automatic clr_counts();
    de_cnt = 0; hs_cnt = 0; vs_cnt = 0; fs_cnt = 0;
  endtask

  task automatic chk_reset_vals(string p);
    chk({p, "_hs"}, lcd_hs, 0);
    chk({p, "_vs"}, lcd_vs, 0);
    chk({p, "_de"}, lcd_de, 0);
    chk({p, "_xpos"}, pif.pixel_xpos, 0);
    chk({p, "_ypos"}, pif.pixel_ypos, 0);
    chk({p, "_rgb"}, lcd_rgb, 0);
    chk({p, "_fs"}, frame_start, 0);
    chk({p, "_bl"}, lcd_bl, 0);
  endtask

  task automatic check_cycle();
    int h, v;
    bit va, de, req;
    logic [10:0] xe, ye;
    rgb_t got;
    if (n > 0 && (n % FR) == 0) begin
      chk("frame_de", de_cnt, HD * VD);
      chk("frame_hs_low", hs_cnt, HS * VT);
      chk("frame_vs_low", vs_cnt, VS * HT);
      chk("frame_fs", fs_cnt, 1);
      clr_counts();
    end
    h = n % HT;
    v = (n / HT) % VT;
    va = (v >= VA) && (v < VA + VD);
    de = va && (h >= HA) && (h < HA + HD);
    req = va && (h >= HA - 1) && (h < HA + HD - 1);
    xe = req ? 11'(h - HA + 1) : 11'd0;
    ye = req ? 11'(v - VA) : 11'd0;
    chk("hs", lcd_hs, h >= HS);
    chk("vs", lcd_vs, v >= VS);
    chk("de", lcd_de, de);
    chk("xpos", pif.pixel_xpos, xe);
    chk("ypos", pif.pixel_ypos, ye);
    chk("fs", frame_start, (h == HA - 1) && (v == VA));
    chk("bl", lcd_bl, edges > 0);
    if (de) begin
      chk("sb_level", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        got = sb.pop_front();
        chk("rgb_active", lcd_rgb, got);
      end
    end else begin
      chk("rgb_blank", lcd_rgb, 0);
    end
    if (req)
      sb.push_back(white ? WHITE : {ye[7:0], xe, 5'b0});
    de_cnt += int'(lcd_de);
    hs_cnt += int'(!lcd_hs);
    vs_cnt += int'(!lcd_vs);
    fs_cnt += int'(frame_start);
    if (prev_vs === 1'b1 && lcd_vs === 1'b0) begin
      if (last_fall >= 0)
        chk("vs_period", cyc - last_fall, FR);
      last_fall = cyc;
    end
    prev_vs = lcd_vs;
  endtask

  task automatic tick();
    @(posedge lcd_pclk);
    n++; edges++; cyc++;
    @(negedge lcd_pclk);
    check_cycle();
  endtask

  initial begin
    int target;
    cyc = 0;
    repeat (3) @(negedge lcd_pclk);
    chk_reset_vals("por");
    chk("h_disp", pif.h_disp, HD);
    chk("v_disp", pif.v_disp, VD);

    rst_n = 1'b1;
    n = 0; edges = 0; last_fall = -1; prev_vs = 1'b0;
    clr_counts();
    check_cycle();
    repeat (2 * FR) tick();

    white = 1'b1;
    repeat (FR) tick();
    white = 1'b0;

    target = 8 * HT + 12;
    for (int i = 0; i < FR && (n % FR) != target; i++) tick();
    chk("reach_mid", n % FR, target);

    @(posedge lcd_pclk);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("mid");
    repeat (3) @(posedge lcd_pclk);
    @(negedge lcd_pclk);
    chk_reset_vals("hold");
    rst_n = 1'b1;
    sb.delete();
    n = 0; edges = 0; prev_vs = 1'b0;
    last_fall = cyc;
    clr_counts();
    check_cycle();
    repeat (FR + HT) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
